// File: rtl/regfile_mrp_pkg.sv
// Shared defaults and element types for the multi-read-port register file.
package regfile_pkg;

    localparam int DEF_DEPTH  = 32;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_AW     = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    addr_t;
    typedef logic [DEF_WIDTH-1:0] data_t;

endpackage

// File: rtl/regfile_mrp_if.sv
// Write port from writeback plus packed read ports from decode, bundled for regfile_mrp.
interface regfile_mrp_if import regfile_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    localparam int AW = $clog2(DEPTH);

    logic                    we;
    logic [AW-1:0]           waddr;
    logic [WIDTH-1:0]        wdata;
    logic [NUM_RD-1:0]       rd_en;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_valid;

    modport master (
        output we, waddr, wdata, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  we, waddr, wdata, rd_en, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/regfile_mrp_addr_decoder.sv
// N-to-2^N one-hot decoder with enable, truncated to DEPTH outputs; out-of-range codes give all-zero.
module addr_decoder #(
    parameter int N     = 5,
    parameter int DEPTH = 32
) (
    input  logic             en,
    input  logic [N-1:0]     addr,
    output logic [DEPTH-1:0] sel
);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (en && (addr == N'(i)))
                sel[i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mrp.sv
// DEPTH x WIDTH register file, one write port, NUM_RD registered read ports.
// Define REGFILE_MRP_BYPASS_EN to forward same-cycle write data onto colliding reads.
module regfile_mrp import regfile_pkg::*; #(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mrp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] wsel_raw;
    logic [DEPTH-1:0] wsel;
    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] rnext [NUM_RD];

    addr_decoder #(
        .N     (AW),
        .DEPTH (DEPTH)
    ) u_wdec (
        .en   (bus.we),
        .addr (bus.waddr),
        .sel  (wsel_raw)
    );

    // Masking the decoder output keeps the bypass qualifier identical to the real write.
    always_comb begin
        wsel = wsel_raw;
        if (ZERO_REG)
            wsel[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
                if (wsel[i])
                    mem[i] <= bus.wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok;

        assign ra    = bus.rd_addr[p*AW +: AW];
        assign ra_ok = (int'(ra) < DEPTH) && !(ZERO_REG && (ra == '0));

`ifdef REGFILE_MRP_BYPASS_EN
        assign rnext[p] = ((|wsel) && (bus.waddr == ra)) ? bus.wdata :
                          ra_ok                          ? mem[ra]   : '0;
`else
        assign rnext[p] = ra_ok ? mem[ra] : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                bus.rd_valid[p] <= bus.rd_en[p];
                if (bus.rd_en[p])
                    bus.rd_data[p*WIDTH +: WIDTH] <= rnext[p];
            end
        end
    end

endmodule
